// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: IDLE accepts, EXEC samples the ALU, RESP holds the result.
module alu_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0V,
    input  logic [15:0] req0A,
    input  logic [15:0] req0B,
    input  logic        req0C,
    input  logic [2:0]  req0Opc,
    output logic        req0Rdy,
    input  logic        req1V,
    input  logic [15:0] req1A,
    input  logic [15:0] req1B,
    input  logic        req1C,
    input  logic [2:0]  req1Opc,
    output logic        req1Rdy,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic        aluC,
    output logic [2:0]  aluOpc,
    input  logic [15:0] aluW,
    input  logic        aluZer,
    input  logic        aluNeg,
    output logic        rspV,
    input  logic        rspRdy,
    output logic [15:0] rspW,
    output logic        rspZer,
    output logic        rspNeg,
    output logic        rspId
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] op_a_q, op_a_d;
    logic [15:0] op_b_q, op_b_d;
    logic        op_c_q, op_c_d;
    logic [2:0]  op_opc_q, op_opc_d;
    logic        id_q, id_d;
    logic [15:0] res_w_q, res_w_d;
    logic        res_zer_q, res_zer_d;
    logic        res_neg_q, res_neg_d;
    logic        sel1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= 1'b0;
            op_opc_q     <= '0;
            id_q         <= 1'b0;
            res_w_q      <= '0;
            res_zer_q    <= 1'b0;
            res_neg_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            op_opc_q     <= op_opc_d;
            id_q         <= id_d;
            res_w_q      <= res_w_d;
            res_zer_q    <= res_zer_d;
            res_neg_q    <= res_neg_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_c_d       = op_c_q;
        op_opc_d     = op_opc_q;
        id_d         = id_q;
        res_w_d      = res_w_q;
        res_zer_d    = res_zer_q;
        res_neg_d    = res_neg_q;
        req0Rdy      = 1'b0;
        req1Rdy      = 1'b0;
        // Requester 1 wins alone, or under contention when 0 was granted last
        sel1         = req1V && (!req0V || !last_grant_q);

        unique case (state_q)
            IDLE: begin
                // Gated by rst_n so no Rdy is presented while held in reset
                req0Rdy = rst_n && req0V && !sel1;
                req1Rdy = rst_n && sel1;
                if (req0V || req1V) begin
                    state_d      = EXEC;
                    last_grant_d = sel1;
                    id_d         = sel1;
                    op_a_d       = sel1 ? req1A   : req0A;
                    op_b_d       = sel1 ? req1B   : req0B;
                    op_c_d       = sel1 ? req1C   : req0C;
                    op_opc_d     = sel1 ? req1Opc : req0Opc;
                end
            end
            EXEC: begin
                res_w_d   = aluW;
                res_zer_d = aluZer;
                res_neg_d = aluNeg;
                state_d   = RESP;
            end
            RESP: begin
                if (rspRdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign aluA   = op_a_q;
    assign aluB   = op_b_q;
    assign aluC   = op_c_q;
    assign aluOpc = op_opc_q;

    assign rspV   = (state_q == RESP);
    assign rspW   = res_w_q;
    assign rspZer = res_zer_q;
    assign rspNeg = res_neg_q;
    assign rspId  = id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for alu_arbiter with a behavioural ALU and
// a transaction-level model of arbitration, latency and backpressure.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0V, req0C, req0Rdy, req1V, req1C, req1Rdy;
    logic [15:0] req0A, req0B, req1A, req1B;
    logic [2:0]  req0Opc, req1Opc;
    logic [15:0] aluA, aluB, aluW;
    logic        aluC, aluZer, aluNeg;
    logic [2:0]  aluOpc;
    logic        rspV, rspRdy, rspZer, rspNeg, rspId;
    logic [15:0] rspW;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0V(req0V), .req0A(req0A), .req0B(req0B), .req0C(req0C), .req0Opc(req0Opc), .req0Rdy(req0Rdy),
        .req1V(req1V), .req1A(req1A), .req1B(req1B), .req1C(req1C), .req1Opc(req1Opc), .req1Rdy(req1Rdy),
        .aluA(aluA), .aluB(aluB), .aluC(aluC), .aluOpc(aluOpc),
        .aluW(aluW), .aluZer(aluZer), .aluNeg(aluNeg),
        .rspV(rspV), .rspRdy(rspRdy), .rspW(rspW), .rspZer(rspZer), .rspNeg(rspNeg), .rspId(rspId)
    );

    function automatic logic [15:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                           input logic c, input logic [2:0] op);
        case (op)
            3'd0:    return a + b + {15'b0, c};
            3'd1:    return a - b;
            3'd2:    return a + b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return a ^ b;
            3'd6:    return ~a;
            default: return b;
        endcase
    endfunction

    always_comb begin
        aluW   = alu_fn(aluA, aluB, aluC, aluOpc);
        aluZer = (aluW == 16'h0000);
        aluNeg = aluW[15];
    end

    typedef struct {
        logic [15:0] w;
        logic        z;
        logic        n;
        logic        id;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    logic last_a0, last_a1;

    function automatic exp_t mk(input logic [15:0] a, input logic [15:0] b, input logic c,
                                input logic [2:0] op, input logic id);
        exp_t e;
        e.w  = alu_fn(a, b, c, op);
        e.z  = (e.w == 16'h0000);
        e.n  = e.w[15];
        e.id = id;
        return e;
    endfunction

    task automatic check(input string nm, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard push: expected response computed from the accepted request
    always @(posedge clk) begin
        if (rst_n) begin
            if (req0V && req0Rdy) sb.push_back(mk(req0A, req0B, req0C, req0Opc, 1'b0));
            if (req1V && req1Rdy) sb.push_back(mk(req1A, req1B, req1C, req1Opc, 1'b1));
        end
    end

    // Monitor with transaction-level model
    logic        m_out = 1'b0, m_last = 1'b1, prev_hold = 1'b0;
    int          m_since = 0;
    logic [15:0] m_a, m_b;
    logic        m_c;
    logic [2:0]  m_opc;
    logic [18:0] prev_rsp;

    always @(negedge clk) begin
        logic e0, e1, ev;
        exp_t e;
        if (!rst_n) begin
            check("reset_rspV", {39'b0, rspV}, 40'd0);
            check("reset_rdy", {38'b0, req0Rdy, req1Rdy}, 40'd0);
            check("reset_aluA", {24'b0, aluA}, 40'd0);
            m_out = 1'b0; m_since = 0; m_last = 1'b1; prev_hold = 1'b0;
            sb.delete();
        end else begin
            e0 = 1'b0; e1 = 1'b0;
            if (!m_out) begin
                if (req0V && req1V) begin e0 = m_last; e1 = !m_last; end
                else begin e0 = req0V; e1 = req1V; end
            end
            check("req0Rdy", {39'b0, req0Rdy}, {39'b0, e0});
            check("req1Rdy", {39'b0, req1Rdy}, {39'b0, e1});
            ev = m_out && (m_since >= 1);
            check("rspV", {39'b0, rspV}, {39'b0, ev});
            if (m_out && m_since == 0)
                check("alu_drive", {4'b0, aluA, aluB, aluC, aluOpc}, {4'b0, m_a, m_b, m_c, m_opc});
            if (prev_hold && rspV)
                check("rsp_hold", {21'b0, rspW, rspZer, rspNeg, rspId}, {21'b0, prev_rsp});
            if (ev && rspRdy) begin
                if (sb.size() == 0) begin
                    check("sb_empty", {39'b0, rspV}, 40'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp", {21'b0, rspW, rspZer, rspNeg, rspId}, {21'b0, e.w, e.z, e.n, e.id});
                end
                m_out = 1'b0;
            end
            prev_hold = rspV && !rspRdy;
            prev_rsp  = {rspW, rspZer, rspNeg, rspId};
            if (e0 || e1) begin
                m_out = 1'b1; m_since = 0; m_last = e1;
                m_a = e1 ? req1A : req0A;   m_b = e1 ? req1B : req0B;
                m_c = e1 ? req1C : req0C;   m_opc = e1 ? req1Opc : req0Opc;
            end else if (m_out) begin
                m_since++;
            end
        end
    end

    task automatic rand_req0();
        req0V = 1'b1; req0A = 16'($urandom); req0B = 16'($urandom);
        req0C = 1'($urandom); req0Opc = 3'($urandom_range(7));
    endtask

    task automatic rand_req1();
        req1V = 1'b1; req1A = 16'($urandom); req1B = 16'($urandom);
        req1C = 1'($urandom); req1Opc = 3'($urandom_range(7));
    endtask

    // One clock of requester/consumer behaviour; held requests persist until accepted
    task automatic cycle_drive(input int unsigned pv0, input int unsigned pv1, input int unsigned prdy);
        @(negedge clk);
        last_a0 = req0V && req0Rdy;
        last_a1 = req1V && req1Rdy;
        @(posedge clk);
        #1;
        if (last_a0) req0V = 1'b0;
        if (last_a1) req1V = 1'b0;
        if (!req0V && $urandom_range(99) < pv0) rand_req0();
        if (!req1V && $urandom_range(99) < pv1) rand_req1();
        rspRdy = ($urandom_range(99) < prdy);
    endtask

    task automatic wait_accept(input int unsigned prdy);
        int k = 0;
        do begin
            cycle_drive(0, 0, prdy);
            k++;
        end while (!(last_a0 || last_a1) && k < 20);
        check("accept_timeout", {39'b0, (last_a0 || last_a1)}, 40'd1);
    endtask

    task automatic drain();
        repeat (10) cycle_drive(0, 0, 100);
    endtask

    initial begin
        int prev;
        rst_n = 1'b0; rspRdy = 1'b0;
        rand_req0(); rand_req1();
        #3;
        check("init_rdy", {38'b0, req0Rdy, req1Rdy}, 40'd0);
        check("init_rsp", {20'b0, rspV, rspW, rspZer, rspNeg, rspId}, 40'd0);
        check("init_alu", {4'b0, aluA, aluB, aluC, aluOpc}, 40'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // Continuous contention: alternating grants starting with requester 0
        repeat (16) cycle_drive(100, 100, 100);
        drain();

        // Single directed op
        req0V = 1'b1; req0A = 16'h0003; req0B = 16'h0005; req0C = 1'b1; req0Opc = 3'b010;
        wait_accept(100);
        check("single_owner", {38'b0, last_a0, last_a1}, 40'd2);
        @(negedge clk);
        check("single_alu", {4'b0, aluA, aluB, aluC, aluOpc}, {4'b0, 16'h0003, 16'h0005, 1'b1, 3'b010});
        @(negedge clk);
        check("single_rsp", {22'b0, rspV, rspW, rspId}, {22'b0, 1'b1, 16'h0008, 1'b0});
        drain();

        // Backpressure with negative-flag result
        req1V = 1'b1; req1A = 16'h1111; req1B = 16'h8000; req1C = 1'b0; req1Opc = 3'd7;
        wait_accept(0);
        repeat (6) cycle_drive(100, 100, 0);
        check("bp_rsp", {21'b0, rspV, rspW, rspZer, rspNeg}, {21'b0, 1'b1, 16'h8000, 1'b0, 1'b1});
        drain();

        // Zero-flag result
        req0V = 1'b1; req0A = 16'h00FF; req0B = 16'h0000; req0C = 1'b0; req0Opc = 3'd7;
        wait_accept(100);
        @(negedge clk); @(negedge clk);
        check("zero_rsp", {21'b0, rspV, rspW, rspZer, rspNeg}, {21'b0, 1'b1, 16'h0000, 1'b1, 1'b0});
        drain();

        // Reset during EXEC
        req1V = 1'b1; req1A = 16'h1234; req1B = 16'h4321; req1C = 1'b1; req1Opc = 3'd0;
        wait_accept(100);
        #2 rst_n = 1'b0;
        #1;
        check("async_rspV", {39'b0, rspV}, 40'd0);
        check("async_aluA", {24'b0, aluA}, 40'd0);
        rand_req0(); rand_req1();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cycle_drive(100, 100, 100);
        check("post_reset_grant", {38'b0, last_a0, last_a1}, 40'd2);
        repeat (8) cycle_drive(100, 100, 100);
        drain();

        // Back-to-back accepts from a single requester
        prev = -1;
        repeat (16) begin
            cycle_drive(0, 100, 100);
            if (last_a1) begin
                if (prev >= 0) check("b2b_spacing", 40'(cyc - prev), 40'd3);
                prev = cyc;
            end
        end
        drain();

        // Randomised traffic
        repeat (8) begin
            int unsigned p0, p1, pr;
            p0 = $urandom_range(100); p1 = $urandom_range(100); pr = $urandom_range(20, 100);
            repeat (50) cycle_drive(p0, p1, pr);
        end
        drain();
        check("sb_drained", 40'(sb.size()), 40'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
